mest_pro_fetch_decode: RTL and testbench

MEST_PRO_FETCH_DECODE -- requirements
Module: mest_pro_fetch_decode

---
 rtl/mest_pro_pkg.sv | 21 ++
 rtl/mest_pro_fetch_decode_if.sv | 27 ++
 rtl/mest_pro_ret_stack.sv | 41 ++++
 rtl/mest_pro_fetch_decode.sv | 134 +++++++++++++
 tb/tb_mest_pro_fetch_decode.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/mest_pro_pkg.sv
// mest_pro_pkg -- definitions shared by the fetch/decode sequencer, its
// bus interface and the optional return stack.
//   state_t      : sequencer states
//   *_LSB/FIELD_W: instruction-word field positions
//   PC_W/INSTR_W : program counter and instruction widths
//   STACK_DEPTH  : return stack entries (used only with MEST_PRO_CALL_STACK_EN)
package mest_pro_pkg;
  localparam int PC_W        = 8;
  localparam int INSTR_W     = 24;
  localparam int FIELD_W     = 8;
  localparam int OPC_LSB     = 16;
  localparam int OP1_LSB     = 8;
  localparam int OP2_LSB     = 0;
  localparam int STACK_DEPTH = 4;
  localparam int SP_W        = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W       = $clog2(STACK_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT_MEM, S_ISSUE, S_WAIT_EXEC, S_HALT
  } state_t;
endpackage

// File: rtl/mest_pro_fetch_decode_if.sv
// mest_pro_fetch_decode_if -- instruction-memory and execute-stage bus.
//   master : the fetch/decode sequencer (drives fetch strobe/address, issue
//            pulse and decoded fields; receives instruction word and flags)
//   slave  : memory / execute side
interface mest_pro_fetch_decode_if;
  import mest_pro_pkg::*;
  logic [PC_W-1:0]    o_imem_addr;
  logic               o_imem_rd;
  logic [INSTR_W-1:0] i_imem_data;
  logic               o_execute;
  logic [FIELD_W-1:0] o_op_code;
  logic [FIELD_W-1:0] o_operand1;
  logic [FIELD_W-1:0] o_operand2;
  logic               i_exec_done;
  logic               i_jump;
  logic               i_return_pc;
  logic               i_end_of_code;

  modport master (
    output o_imem_addr, o_imem_rd, o_execute, o_op_code, o_operand1, o_operand2,
    input  i_imem_data, i_exec_done, i_jump, i_return_pc, i_end_of_code
  );
  modport slave (
    input  o_imem_addr, o_imem_rd, o_execute, o_op_code, o_operand1, o_operand2,
    output i_imem_data, i_exec_done, i_jump, i_return_pc, i_end_of_code
  );
endinterface

// File: rtl/mest_pro_ret_stack.sv
// mest_pro_ret_stack -- STACK_DEPTH-entry LIFO of return addresses.
//   clk, i_reset : clock, synchronous active-high reset (clears entries + sp)
//   push, pop    : one operation per cycle; caller guards against full/empty
//   push_data    : address to push
//   full, empty  : occupancy flags
//   data         : top-of-stack entry (meaningless while empty)
module mest_pro_ret_stack
  import mest_pro_pkg::*;
(
  input  logic            clk,
  input  logic            i_reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic            full,
  output logic            empty,
  output logic [PC_W-1:0] data
);
  logic [STACK_DEPTH-1:0][PC_W-1:0] mem;
  logic [SP_W-1:0]                  sp;
  logic [IDX_W-1:0]                 top_idx;
  logic [IDX_W-1:0]                 wr_idx;

  assign full    = (sp == SP_W'(STACK_DEPTH));
  assign empty   = (sp == '0);
  assign top_idx = IDX_W'(sp - 1'b1);
  assign wr_idx  = IDX_W'(sp);
  assign data    = mem[top_idx];

  always_ff @(posedge clk) begin
    if (i_reset) begin
      mem <= '0;
      sp  <= '0;
    end else if (push && !full) begin
      mem[wr_idx] <= push_data;
      sp          <= sp + 1'b1;
    end else if (pop && !empty) begin
      sp <= sp - 1'b1;
    end
  end
endmodule

// File: rtl/mest_pro_fetch_decode.sv
// mest_pro_fetch_decode -- single-issue fetch/decode sequencer.
// Walks IDLE -> FETCH -> WAIT_MEM -> ISSUE -> WAIT_EXEC and picks the next PC
// from the execute-stage flags (end_of_code > jump > return > sequential).
// Ports:
//   clk, i_reset : clock, synchronous active-high reset
//   i_start      : one-cycle start pulse, honoured only in IDLE
//   bus          : memory/execute bus (master side)
//   o_pc         : current program counter
//   o_busy       : any state other than IDLE/HALT
//   o_halted     : in HALT (left only by reset)
//   o_stack_err  : sticky call-stack overflow/underflow
// Build option: define MEST_PRO_CALL_STACK_EN to add a 4-deep return stack;
// without it a return just advances the PC and o_stack_err is tied low.
module mest_pro_fetch_decode
  import mest_pro_pkg::*;
(
  input  logic                     clk,
  input  logic                     i_reset,
  input  logic                     i_start,
  mest_pro_fetch_decode_if.master  bus,
  output logic [PC_W-1:0]          o_pc,
  output logic                     o_busy,
  output logic                     o_halted,
  output logic                     o_stack_err
);
  state_t             state, state_nxt;
  logic [PC_W-1:0]    pc, pc_nxt, pc_inc;
  logic [INSTR_W-1:0] ir;
  logic [PC_W-1:0]    jmp_tgt;

  assign pc_inc  = pc + 8'd1;
  assign jmp_tgt = ir[OP2_LSB +: FIELD_W];

`ifdef MEST_PRO_CALL_STACK_EN
  logic            push, pop, stk_full, stk_empty, err, err_nxt;
  logic [PC_W-1:0] stk_data;

  mest_pro_ret_stack u_stack (
    .clk       (clk),
    .i_reset   (i_reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .full      (stk_full),
    .empty     (stk_empty),
    .data      (stk_data)
  );

  always_ff @(posedge clk) begin
    if (i_reset) err <= 1'b0;
    else         err <= err_nxt;
  end
  assign o_stack_err = err;
`else
  assign o_stack_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state <= S_IDLE;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (state == S_WAIT_MEM) ir <= bus.i_imem_data;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
`ifdef MEST_PRO_CALL_STACK_EN
    push      = 1'b0;
    pop       = 1'b0;
    err_nxt   = err;
`endif
    unique case (state)
      S_IDLE:      if (i_start) state_nxt = S_FETCH;
      S_FETCH:     state_nxt = S_WAIT_MEM;
      S_WAIT_MEM:  state_nxt = S_ISSUE;
      S_ISSUE:     state_nxt = S_WAIT_EXEC;
      S_WAIT_EXEC: begin
        // flags are only meaningful in the done cycle
        if (bus.i_exec_done) begin
          state_nxt = S_FETCH;
          if (bus.i_end_of_code) begin
            state_nxt = S_HALT;
          end else if (bus.i_jump) begin
`ifdef MEST_PRO_CALL_STACK_EN
            if (stk_full) begin
              state_nxt = S_HALT;
              err_nxt   = 1'b1;
            end else begin
              push   = 1'b1;
              pc_nxt = jmp_tgt;
            end
`else
            pc_nxt = jmp_tgt;
`endif
          end else if (bus.i_return_pc) begin
`ifdef MEST_PRO_CALL_STACK_EN
            if (stk_empty) begin
              state_nxt = S_HALT;
              err_nxt   = 1'b1;
            end else begin
              pop    = 1'b1;
              pc_nxt = stk_data;
            end
`else
            pc_nxt = pc_inc;
`endif
          end else begin
            pc_nxt = pc_inc;
          end
        end
      end
      S_HALT:      state_nxt = S_HALT;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Outputs are gated by i_reset so they read 0 during the reset cycle
  // itself, not just after the reset edge.
  assign bus.o_imem_rd   = (state == S_FETCH) && !i_reset;
  assign bus.o_imem_addr = bus.o_imem_rd ? pc : '0;
  assign bus.o_execute   = (state == S_ISSUE) && !i_reset;
  assign bus.o_op_code   = i_reset ? '0 : ir[OPC_LSB +: FIELD_W];
  assign bus.o_operand1  = i_reset ? '0 : ir[OP1_LSB +: FIELD_W];
  assign bus.o_operand2  = i_reset ? '0 : ir[OP2_LSB +: FIELD_W];
  assign o_busy          = !i_reset && (state != S_IDLE) && (state != S_HALT);
  assign o_halted        = !i_reset && (state == S_HALT);
  assign o_pc            = pc;
endmodule

// File: tb/tb_mest_pro_fetch_decode.sv
// tb_mest_pro_fetch_decode -- scoreboard bench for mest_pro_fetch_decode.
// A per-step flag table drives the execute side; a reference PC model pushes
// the expected fetch addresses, fetches push the expected instruction word,
// and issue pulses pop/compare the decoded fields. Stack scenarios are
// built only when MEST_PRO_CALL_STACK_EN is defined.
module tb_mest_pro_fetch_decode;
  import mest_pro_pkg::*;

  logic       clk = 1'b0;
  logic       i_reset, i_start;
  logic [7:0] o_pc;
  logic       o_busy, o_halted, o_stack_err;

  mest_pro_fetch_decode_if bus ();

  mest_pro_fetch_decode dut (
    .clk         (clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .bus         (bus),
    .o_pc        (o_pc),
    .o_busy      (o_busy),
    .o_halted    (o_halted),
    .o_stack_err (o_stack_err)
  );

  always #5 clk = ~clk;

  int          n_vec = 0, n_err = 0;
  logic [23:0] imem [256];
  logic [7:0]  exp_addr_q [$];
  logic [23:0] exp_ins_q  [$];
  logic [2:0]  step_q     [$];   // {end_of_code, jump, return}
  logic [7:0]  mstk       [$];
  logic [7:0]  mpc;
  logic        m_halt, m_err, model_on, gap_chk, saw_exec;
  logic [2:0]  cur_fl;
  int          dly, cnt, cyc, last_exec;

  function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endfunction

  // Reference next-PC model, applied in the done cycle.
  function automatic void model_done(logic [2:0] fl);
    logic [7:0] ret;
    ret = mpc + 8'd1;
    if (fl[2]) m_halt = 1'b1;
    else if (fl[1]) begin
`ifdef MEST_PRO_CALL_STACK_EN
      if (mstk.size() == 4) begin m_halt = 1'b1; m_err = 1'b1; end
      else begin mstk.push_back(ret); mpc = imem[mpc][7:0]; end
`else
      mpc = imem[mpc][7:0];
`endif
    end else if (fl[0]) begin
`ifdef MEST_PRO_CALL_STACK_EN
      if (mstk.size() == 0) begin m_halt = 1'b1; m_err = 1'b1; end
      else mpc = mstk.pop_back();
`else
      mpc = ret;
`endif
    end else mpc = ret;
    if (!m_halt) exp_addr_q.push_back(mpc);
  endfunction

  task automatic tick();
    logic [7:0]  a;
    logic [23:0] w;
    @(negedge clk);
    cyc++;
    bus.i_exec_done = 1'b0;
    {bus.i_end_of_code, bus.i_jump, bus.i_return_pc} = 3'($urandom);
    if (bus.o_imem_rd) begin
      if (exp_addr_q.size() == 0) chk("spurious_rd", 32'(bus.o_imem_rd), 32'd0);
      else begin
        a = exp_addr_q.pop_front();
        chk("fetch_addr", 32'(bus.o_imem_addr), 32'(a));
        exp_ins_q.push_back(imem[a]);
      end
      bus.i_imem_data = imem[bus.o_imem_addr];
    end
    if (bus.o_execute) begin
      saw_exec = 1'b1;
      if (exp_ins_q.size() == 0) chk("spurious_exec", 32'(bus.o_execute), 32'd0);
      else begin
        w = exp_ins_q.pop_front();
        chk("decode", 32'({bus.o_op_code, bus.o_operand1, bus.o_operand2}), 32'(w));
      end
      if (gap_chk && last_exec >= 0) chk("cpi", 32'(cyc - last_exec), 32'd4);
      last_exec = cyc;
      cur_fl = (step_q.size() != 0) ? step_q.pop_front() : 3'b100;
      cnt = dly;
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        bus.i_exec_done = 1'b1;
        {bus.i_end_of_code, bus.i_jump, bus.i_return_pc} = cur_fl;
        if (model_on) model_done(cur_fl);
      end
    end
  endtask

  task automatic init(int d);
    for (int i = 0; i < 256; i++) imem[i] = 24'($urandom);
    exp_addr_q.delete(); exp_ins_q.delete(); step_q.delete(); mstk.delete();
    mpc = 8'd0; m_halt = 1'b0; m_err = 1'b0; model_on = 1'b1;
    dly = d; cnt = 0; last_exec = -1; gap_chk = (d == 1); saw_exec = 1'b0;
    exp_addr_q.push_back(8'd0);
    i_start = 1'b0;
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
  endtask

  task automatic run(int budget);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < budget && !o_halted; i++) tick();
    chk("halted", 32'(o_halted), 32'(m_halt));
    chk("end_pc", 32'(o_pc), 32'(mpc));
    chk("stack_err", 32'(o_stack_err), 32'(m_err));
    chk("busy_at_end", 32'(o_busy), 32'd0);
    chk("fetches_left", 32'(exp_addr_q.size()), 32'd0);
  endtask

  initial begin
    i_reset = 1'b1; i_start = 1'b0;
    bus.i_imem_data = '0; bus.i_exec_done = 1'b0;
    bus.i_jump = 1'b0; bus.i_return_pc = 1'b0; bus.i_end_of_code = 1'b0;

    // Three sequential instructions then end at PC 3.
    init(1);
    chk("rst_pc", 32'(o_pc), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_halted", 32'(o_halted), 32'd0);
    chk("rst_rd", 32'(bus.o_imem_rd), 32'd0);
    chk("rst_exec", 32'(bus.o_execute), 32'd0);
    chk("rst_stack_err", 32'(o_stack_err), 32'd0);
    chk("rst_opcode", 32'(bus.o_op_code), 32'd0);
    step_q = '{3'b000, 3'b000, 3'b000, 3'b100};
    run(100);

    // Jump at PC 5 to 0x40, return at 0x40, then end.
    init(1);
    imem[5][7:0] = 8'h40;
    step_q = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b001, 3'b100};
    run(200);

    // End-of-code beats jump at PC 9; start pulses in HALT are ignored.
    init(1);
    step_q = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
               3'b000, 3'b000, 3'b000, 3'b000, 3'b110};
    run(200);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("halt_sticky", 32'(o_halted), 32'd1);
    chk("halt_pc", 32'(o_pc), 32'd9);

    // PC 0xFF with no flags wraps to 0.
    init(1);
    imem[0][7:0] = 8'hFF;
    step_q = '{3'b010, 3'b000, 3'b100};
    run(100);

`ifdef MEST_PRO_CALL_STACK_EN
    // Five nested jumps overflow the stack.
    init(1);
    imem[8'h00][7:0] = 8'h10; imem[8'h10][7:0] = 8'h20;
    imem[8'h20][7:0] = 8'h30; imem[8'h30][7:0] = 8'h40;
    step_q = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010};
    run(200);

    // Return on empty stack.
    init(1);
    step_q = '{3'b001};
    run(100);
`endif

    // Reset in WAIT_EXEC with done delayed 10 cycles; late done is ignored.
    init(10);
    step_q = '{3'b000};
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 20 && !saw_exec; i++) tick();
    chk("saw_exec", 32'(saw_exec), 32'd1);
    for (int i = 0; i < 3; i++) tick();
    chk("busy_wait_exec", 32'(o_busy), 32'd1);
    model_on = 1'b0;
    exp_addr_q.delete();
    i_reset = 1'b1;
    #1;
    chk("inrst_exec", 32'(bus.o_execute), 32'd0);
    chk("inrst_busy", 32'(o_busy), 32'd0);
    chk("inrst_opcode", 32'(bus.o_op_code), 32'd0);
    tick();
    i_reset = 1'b0;
    chk("postrst_pc", 32'(o_pc), 32'd0);
    chk("postrst_busy", 32'(o_busy), 32'd0);
    for (int i = 0; i < 15; i++) tick();
    chk("late_done_busy", 32'(o_busy), 32'd0);
    chk("late_done_pc", 32'(o_pc), 32'd0);
    chk("late_done_halt", 32'(o_halted), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
